// File: rtl/acc_alu_unit.sv
// Accumulator + ALU datapath: ACC register, Z/C flags, valid/ready command port,
// single-cycle arithmetic/logic/shift ops and a bit-serial shift-add multiply.
module acc_alu_unit #(
  parameter int WIDTH     = 8,
  parameter int IMM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic                 b_sel,
  input  logic [WIDTH-1:0]     mem_data,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     acc,
  output logic                 zf,
  output logic                 cf,
  output logic                 busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_ADC = 4'h6;
  localparam logic [3:0] OP_SBC = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_LDA = 4'hD;
  localparam logic [3:0] OP_CLR = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  logic [0:0]         state_q,  state_d;
  logic [WIDTH-1:0]   acc_q,    acc_d;
  logic               zf_q,     zf_d;
  logic               cf_q,     cf_d;
  logic               ov_q,     ov_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;

  logic [WIDTH-1:0]   b_operand;
  logic               carry_in;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cf;
  logic [2*WIDTH-1:0] prod_step;

  assign b_operand = b_sel ? WIDTH'(imm) : mem_data;

  // ADC/SBC fold the old carry in; plain ADD/SUB share the same adders with carry_in=0.
  assign carry_in = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? cf_q : 1'b0;
  assign add_sum  = {1'b0, acc_q} + {1'b0, b_operand} + {{WIDTH{1'b0}}, carry_in};
  assign sub_diff = {1'b0, acc_q} - {1'b0, b_operand} - {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    alu_res = acc_q;
    alu_cf  = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_cf  = add_sum[WIDTH];
      end
      OP_SUB, OP_SBC: begin
        alu_res = sub_diff[WIDTH-1:0];
        alu_cf  = sub_diff[WIDTH];
      end
      OP_AND: alu_res = acc_q & b_operand;
      OP_OR:  alu_res = acc_q | b_operand;
      OP_XOR: alu_res = acc_q ^ b_operand;
      OP_NOT: alu_res = ~acc_q;
      OP_SHL: begin
        alu_res = {acc_q[WIDTH-2:0], 1'b0};
        alu_cf  = acc_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, acc_q[WIDTH-1:1]};
        alu_cf  = acc_q[0];
      end
      OP_ROL: begin
        alu_res = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
        alu_cf  = acc_q[WIDTH-1];
      end
      OP_ROR: begin
        alu_res = {acc_q[0], acc_q[WIDTH-1:1]};
        alu_cf  = acc_q[0];
      end
      OP_LDA: alu_res = b_operand;
      OP_CLR: alu_res = '0;
      default: begin
        alu_res = acc_q;
        alu_cf  = cf_q;
      end
    endcase
  end

  // One multiplier bit per cycle, LSB first; the multiplicand walks left.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    ov_d     = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MUL) begin
            state_d  = ST_MUL;
            cnt_d    = CNT_W'(WIDTH);
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = b_operand;
          end else if (opcode == OP_NOP) begin
            ov_d = 1'b1;
          end else begin
            acc_d = alu_res;
            cf_d  = alu_cf;
            zf_d  = (alu_res == '0);
            ov_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        prod_d   = prod_step;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          acc_d   = prod_step[WIDTH-1:0];
          cf_d    = |prod_step[2*WIDTH-1:WIDTH];
          zf_d    = (prod_step[WIDTH-1:0] == '0);
          ov_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      ov_q     <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      ov_q     <= ov_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL);
  assign out_valid = ov_q;
  assign acc       = acc_q;
  assign zf        = zf_q;
  assign cf        = cf_q;

endmodule

// File: tb/tb_acc_alu_unit.sv
// Bench for acc_alu_unit: an 8-bit and a 16-bit instance, with a reference model
// feeding per-instance scoreboards that are drained on every out_valid pulse.
module tb_acc_alu_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        v8 = 1'b0, rdy8, bs8 = 1'b0, ov8, zf8, cf8, busy8;
  logic [3:0]  op8 = 4'h0, imm8 = 4'h0;
  logic [7:0]  mem8 = 8'h00, acc8;

  logic        v16 = 1'b0, rdy16, bs16 = 1'b0, ov16, zf16, cf16, busy16;
  logic [3:0]  op16 = 4'h0;
  logic [5:0]  imm16 = 6'h00;
  logic [15:0] mem16 = 16'h0000, acc16;

  acc_alu_unit #(.WIDTH(8), .IMM_WIDTH(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .opcode(op8), .b_sel(bs8),
    .mem_data(mem8), .imm(imm8), .out_valid(ov8), .acc(acc8), .zf(zf8), .cf(cf8), .busy(busy8)
  );

  acc_alu_unit #(.WIDTH(16), .IMM_WIDTH(6)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .opcode(op16), .b_sel(bs16),
    .mem_data(mem16), .imm(imm16), .out_valid(ov16), .acc(acc16), .zf(zf16), .cf(cf16), .busy(busy16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0]  q8[$];
  logic [17:0] q16[$];

  int m_acc = 0;
  bit m_zf  = 1'b0;
  bit m_cf  = 1'b0;

  // Reference model of the 8-bit instance, written in plain integer arithmetic.
  task automatic model_step(input int op, input int b);
    int a = m_acc;
    int c = m_cf;
    int r = 0;
    bit nc = 1'b0;
    if (op == 15) begin
      q8.push_back({8'(m_acc), m_zf, m_cf});
      return;
    end
    case (op)
      0:  begin r = a + b;     nc = (r > 255);   end
      1:  begin r = a - b;     nc = (a < b);     end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a;
      6:  begin r = a + b + c; nc = (r > 255);   end
      7:  begin r = a - b - c; nc = (a < b + c); end
      8:  begin r = a * 2;     nc = (a >= 128);  end
      9:  begin r = a / 2;     nc = (a % 2 == 1); end
      10: begin r = a * 2 + a / 128; nc = (a >= 128); end
      11: begin r = a / 2 + (a % 2) * 128; nc = (a % 2 == 1); end
      12: begin r = a * b;     nc = (r > 255);   end
      13: r = b;
      default: r = 0;
    endcase
    m_acc = r & 255;
    m_cf  = nc;
    m_zf  = (m_acc == 0);
    q8.push_back({8'(m_acc), m_zf, m_cf});
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_zf  = 1'b0;
    m_cf  = 1'b0;
    q8.delete();
    q16.delete();
  endtask

  // Drive one command on the 8-bit instance from edge+1 through its accept edge.
  task automatic issue(input int op, input logic bsel, input int mem, input int im);
    op8  = 4'(op);
    bs8  = bsel;
    mem8 = 8'(mem);
    imm8 = 4'(im);
    v8   = 1'b1;
    model_step(op, bsel ? (im & 15) : (mem & 255));
    @(posedge clk);
    #1;
    v8 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      n_checks++;
      if (q8.size() == 0) begin
        $display("FAIL sb8_unexpected got out_valid acc=%h want no out_valid", acc8);
      end else begin
        logic [9:0] e;
        e = q8.pop_front();
        if ({acc8, zf8, cf8} !== e)
          $display("FAIL sb8_result got acc=%h zf=%b cf=%b want acc=%h zf=%b cf=%b",
                   acc8, zf8, cf8, e[9:2], e[1], e[0]);
        else begin
          n_pass++;
          $display("txn w8  acc=%h zf=%b cf=%b", acc8, zf8, cf8);
        end
      end
    end
    if (ov16 === 1'b1) begin
      n_checks++;
      if (q16.size() == 0) begin
        $display("FAIL sb16_unexpected got out_valid acc=%h want no out_valid", acc16);
      end else begin
        logic [17:0] e;
        e = q16.pop_front();
        if ({acc16, zf16, cf16} !== e)
          $display("FAIL sb16_result got acc=%h zf=%b cf=%b want acc=%h zf=%b cf=%b",
                   acc16, zf16, cf16, e[17:2], e[1], e[0]);
        else begin
          n_pass++;
          $display("txn w16 acc=%h zf=%b cf=%b", acc16, zf16, cf16);
        end
      end
    end
  end

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({acc8, zf8, cf8, ov8, rdy8, busy8} !== {8'h00, 5'b00010})
      $display("FAIL reset_init got acc=%h zf=%b cf=%b ov=%b rdy=%b busy=%b want 00 0 0 0 1 0",
               acc8, zf8, cf8, ov8, rdy8, busy8);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    issue(13, 1'b0, 8'h55, 0);
    issue(0, 1'b1, 0, 3);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({acc8, zf8, cf8, ov8, rdy8, busy8} !== {8'h00, 5'b00010})
      $display("FAIL reset_mid got acc=%h zf=%b cf=%b ov=%b rdy=%b busy=%b want 00 0 0 0 1 0",
               acc8, zf8, cf8, ov8, rdy8, busy8);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_add();
    issue(13, 1'b0, 8'hF0, 0);
    issue(0, 1'b1, 0, 4'hF);
    n_checks++;
    if ({ov8, acc8, cf8} !== {1'b1, 8'hFF, 1'b0})
      $display("FAIL t2_add_ff got ov=%b acc=%h cf=%b want 1 ff 0", ov8, acc8, cf8);
    else n_pass++;
    issue(0, 1'b1, 0, 4'h1);
    n_checks++;
    if ({ov8, acc8, zf8, cf8} !== {1'b1, 8'h00, 1'b1, 1'b1})
      $display("FAIL t2_add_wrap got ov=%b acc=%h zf=%b cf=%b want 1 00 1 1", ov8, acc8, zf8, cf8);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (ov8 !== 1'b0)
      $display("FAIL t2_single_pulse got ov=%b want 0", ov8);
    else n_pass++;
  endtask

  task automatic test_carry();
    issue(6, 1'b1, 0, 0);
    n_checks++;
    if ({acc8, cf8} !== {8'h01, 1'b0}) $display("FAIL t3_adc got acc=%h cf=%b want 01 0", acc8, cf8);
    else n_pass++;
    issue(7, 1'b0, 8'h02, 0);
    n_checks++;
    if ({acc8, cf8} !== {8'hFF, 1'b1}) $display("FAIL t3_sbc got acc=%h cf=%b want ff 1", acc8, cf8);
    else n_pass++;
    issue(9, 1'b0, 0, 0);
    n_checks++;
    if ({acc8, cf8} !== {8'h7F, 1'b1}) $display("FAIL t3_shr got acc=%h cf=%b want 7f 1", acc8, cf8);
    else n_pass++;
    issue(10, 1'b0, 0, 0);
    n_checks++;
    if ({acc8, cf8} !== {8'hFE, 1'b0}) $display("FAIL t3_rol got acc=%h cf=%b want fe 0", acc8, cf8);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int op;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 15);
      if (op == 12) op = 11;
      issue(op, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 15));
      n_checks++;
      if (ov8 !== 1'b1) $display("FAIL b2b_throughput got ov=%b want 1 (op %0d)", ov8, op);
      else n_pass++;
    end
  endtask

  task automatic test_mul();
    int k;
    issue(13, 1'b0, 8'h12, 0);
    issue(12, 1'b0, 8'h10, 0);
    for (k = 1; k <= 20; k++) begin
      n_checks++;
      if ({busy8, rdy8, ov8, acc8} !== {3'b100, 8'h12})
        $display("FAIL t4_busy got busy=%b rdy=%b ov=%b acc=%h want 1 0 0 12", busy8, rdy8, ov8, acc8);
      else n_pass++;
      if (k == 2 || k == 4 || k == 6) begin
        op8 = 4'h0; bs8 = 1'b1; imm8 = 4'h7; v8 = 1'b1;
      end
      @(posedge clk);
      #1;
      v8 = 1'b0;
      if (ov8 === 1'b1) break;
    end
    n_checks++;
    if (k !== 8) $display("FAIL t4_latency got %0d want 8", k);
    else n_pass++;
    n_checks++;
    if ({acc8, cf8, zf8, rdy8, busy8} !== {8'h20, 4'b1010})
      $display("FAIL t4_result got acc=%h cf=%b zf=%b rdy=%b busy=%b want 20 1 0 1 0",
               acc8, cf8, zf8, rdy8, busy8);
    else n_pass++;
  endtask

  task automatic test_mul_reset();
    int seen = 0;
    issue(13, 1'b1, 0, 5);
    issue(12, 1'b0, 7, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({acc8, busy8, ov8, rdy8} !== {8'h00, 3'b001})
      $display("FAIL t5_abort got acc=%h busy=%b ov=%b rdy=%b want 00 0 0 1", acc8, busy8, ov8, rdy8);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ov8 === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL t5_no_ov got %0d pulses want 0", seen);
    else n_pass++;
    issue(13, 1'b1, 0, 3);
    n_checks++;
    if ({ov8, acc8} !== {1'b1, 8'h03}) $display("FAIL t5_lda got ov=%b acc=%h want 1 03", ov8, acc8);
    else n_pass++;
  endtask

  task automatic test_wide();
    int k;
    op16 = 4'hD; bs16 = 1'b1; imm16 = 6'h3F; v16 = 1'b1;
    q16.push_back({16'h003F, 2'b00});
    @(posedge clk);
    #1;
    n_checks++;
    if ({ov16, acc16} !== {1'b1, 16'h003F}) $display("FAIL t6_imm got ov=%b acc=%h want 1 003f", ov16, acc16);
    else n_pass++;
    op16 = 4'hD; bs16 = 1'b0; mem16 = 16'hFFFF;
    q16.push_back({16'hFFFF, 2'b00});
    @(posedge clk);
    #1;
    op16 = 4'hC;
    q16.push_back({16'h0001, 2'b01});
    @(posedge clk);
    #1;
    v16 = 1'b0;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (ov16 === 1'b1) break;
    end
    n_checks++;
    if (k !== 16) $display("FAIL t6_latency got %0d want 16", k);
    else n_pass++;
    n_checks++;
    if ({acc16, cf16, zf16} !== {16'h0001, 2'b10})
      $display("FAIL t6_mul got acc=%h cf=%b zf=%b want 0001 1 0", acc16, cf16, zf16);
    else n_pass++;
    op16 = 4'hF; v16 = 1'b1;
    q16.push_back({16'h0001, 2'b01});
    @(posedge clk);
    #1;
    v16 = 1'b0;
    n_checks++;
    if ({ov16, acc16, zf16, cf16} !== {1'b1, 16'h0001, 2'b01})
      $display("FAIL t6_nop got ov=%b acc=%h zf=%b cf=%b want 1 0001 0 1", ov16, acc16, zf16, cf16);
    else n_pass++;
  endtask

  task automatic test_drain();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (q8.size() + q16.size() != 0)
      $display("FAIL drain got %0d outstanding want 0", q8.size() + q16.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_back_to_back();
    test_mul();
    test_mul_reset();
    test_wide();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
